// File: rtl/bsg_link_traffic_node.sv
// Link traffic generator/checker: each channel sends sequenced payloads on TX and checks that
// the same sequence arrives on its paired RX, under one IDLE/RUN/DRAIN/DONE controller.
module bsg_link_traffic_node #(
    parameter int unsigned width_p     = 32,
    parameter int unsigned channels_p  = 2,
    parameter int unsigned cnt_width_p = 32,
    parameter logic [31:0] offset_p    = 32'h1000_0000,
    parameter int unsigned quiet_p     = 64
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              start_i,
    input  logic                              en_i,
    input  logic                              burst_mode_i,
    input  logic [15:0]                       burst_len_i,
    output logic [channels_p*width_p-1:0]     tx_data_o,
    output logic [channels_p-1:0]             tx_v_o,
    input  logic [channels_p-1:0]             tx_ready_i,
    input  logic [channels_p*width_p-1:0]     rx_data_i,
    input  logic [channels_p-1:0]             rx_v_i,
    output logic [channels_p-1:0]             rx_yumi_o,
    output logic [channels_p*cnt_width_p-1:0] sent_o,
    output logic [channels_p*cnt_width_p-1:0] received_o,
    output logic [channels_p*cnt_width_p-1:0] err_count_o,
    output logic [channels_p-1:0]             error_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned CmpW   = (cnt_width_p > 16) ? cnt_width_p : 16;
    localparam int unsigned QuietW = $clog2(quiet_p + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic               burst_mode_q, burst_mode_d;
    logic [15:0]        burst_len_q, burst_len_d;
    logic [QuietW-1:0]  quiet_q, quiet_d;
    logic               start_run, running, all_sent;

    logic [channels_p-1:0][width_p-1:0]     tx_data_q, tx_data_d, rx_exp_q, rx_exp_d, rx_data;
    logic [channels_p-1:0][cnt_width_p-1:0] sent_q, sent_d, recv_q, recv_d, err_cnt_q, err_cnt_d;
    logic [channels_p-1:0]                  tx_v_q, tx_v_d, error_q, error_d, rx_bad;

    // Channel c's payloads are offset by c*offset_p, truncated to the payload width.
    function automatic logic [width_p-1:0] chan_base(input int unsigned c);
        return width_p'(64'(c) * 64'(offset_p));
    endfunction

    assign rx_data = rx_data_i;
    assign running = (state_q == StRun) || (state_q == StDrain);

    always_comb begin
        all_sent = 1'b1;
        for (int c = 0; c < channels_p; c++) begin
            if (CmpW'(sent_q[c]) < CmpW'(burst_len_q)) all_sent = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_mode_d = burst_mode_q;
        burst_len_d  = burst_len_q;
        quiet_d      = quiet_q;
        start_run    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d      = StRun;
                    start_run    = 1'b1;
                    burst_mode_d = burst_mode_i;
                    burst_len_d  = burst_len_i;
                end
            end
            StRun: begin
                quiet_d = '0;
                if (burst_mode_q ? all_sent : !en_i) state_d = StDrain;
            end
            StDrain: begin
                if (|rx_v_i) quiet_d = '0;
                else if (quiet_q == QuietW'(quiet_p - 1)) state_d = StDone;
                else quiet_d = quiet_q + QuietW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_data_d = tx_data_q;
        rx_exp_d  = rx_exp_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        err_cnt_d = err_cnt_q;
        error_d   = error_q;
        tx_v_d    = '0;
        rx_bad    = '0;
        for (int c = 0; c < channels_p; c++) begin
            if (start_run) begin
                tx_data_d[c] = chan_base(c);
                rx_exp_d[c]  = chan_base(c);
                sent_d[c]    = '0;
                recv_d[c]    = '0;
                err_cnt_d[c] = '0;
                error_d[c]   = 1'b0;
            end else begin
                if (tx_v_q[c] && tx_ready_i[c]) begin
                    tx_data_d[c] = tx_data_q[c] + width_p'(1);
                    sent_d[c]    = sent_q[c] + cnt_width_p'(1);
                end
                if (rx_v_i[c]) begin
                    if (running) begin
                        recv_d[c]   = recv_q[c] + cnt_width_p'(1);
                        rx_exp_d[c] = rx_exp_q[c] + width_p'(1);
                        rx_bad[c]   = (rx_data[c] != rx_exp_q[c]);
                    end else begin
                        rx_bad[c] = 1'b1;
                    end
                end
                if (rx_bad[c]) begin
                    error_d[c] = 1'b1;
                    if (err_cnt_q[c] != '1) err_cnt_d[c] = err_cnt_q[c] + cnt_width_p'(1);
                end
            end
            // A stalled valid is held through any state change until it is accepted.
            tx_v_d[c] = (tx_v_q[c] & ~tx_ready_i[c] & ~start_run)
                      | ((state_d == StRun)
                         & (~burst_mode_d | (CmpW'(sent_d[c]) < CmpW'(burst_len_d))));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            burst_mode_q <= 1'b0;
            burst_len_q  <= '0;
            quiet_q      <= '0;
            tx_data_q    <= '0;
            rx_exp_q     <= '0;
            sent_q       <= '0;
            recv_q       <= '0;
            err_cnt_q    <= '0;
            error_q      <= '0;
            tx_v_q       <= '0;
        end else begin
            state_q      <= state_d;
            burst_mode_q <= burst_mode_d;
            burst_len_q  <= burst_len_d;
            quiet_q      <= quiet_d;
            tx_data_q    <= tx_data_d;
            rx_exp_q     <= rx_exp_d;
            sent_q       <= sent_d;
            recv_q       <= recv_d;
            err_cnt_q    <= err_cnt_d;
            error_q      <= error_d;
            tx_v_q       <= tx_v_d;
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_v_o      = tx_v_q;
    assign rx_yumi_o   = rx_v_i;
    assign sent_o      = sent_q;
    assign received_o  = recv_q;
    assign err_count_o = err_cnt_q;
    assign error_o     = error_q;
    assign busy_o      = running;
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_bsg_link_traffic_node.sv
// Bench for bsg_link_traffic_node: reference model on a 32-bit instance, plus a narrow
// instance for payload wrap and error-count saturation.
module tb_bsg_link_traffic_node;

    localparam logic [31:0] Off = 32'h1000_0000;
    localparam int unsigned Quiet = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Instance A: default widths, loopback with optional corruption.
    logic        a_start, a_en, a_burst, a_busy, a_done, a_loop;
    logic [15:0] a_len;
    logic [63:0] a_tx_data, a_rx_data, a_sent, a_recv, a_errc, a_corrupt, a_rx_drive;
    logic [1:0]  a_tx_v, a_ready, a_rx_v, a_yumi, a_error, a_rx_v_drive;
    assign a_rx_v    = a_loop ? (a_tx_v & a_ready) : a_rx_v_drive;
    assign a_rx_data = a_loop ? (a_tx_data ^ a_corrupt) : a_rx_drive;

    bsg_link_traffic_node dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(a_start), .en_i(a_en),
        .burst_mode_i(a_burst), .burst_len_i(a_len),
        .tx_data_o(a_tx_data), .tx_v_o(a_tx_v), .tx_ready_i(a_ready),
        .rx_data_i(a_rx_data), .rx_v_i(a_rx_v), .rx_yumi_o(a_yumi),
        .sent_o(a_sent), .received_o(a_recv), .err_count_o(a_errc), .error_o(a_error),
        .busy_o(a_busy), .done_o(a_done)
    );

    // Instance B: 8-bit payloads, 4-bit counters, short drain.
    logic        b_start, b_en, b_burst, b_busy, b_done;
    logic [15:0] b_len, b_tx_data, b_rx_data;
    logic [1:0]  b_tx_v, b_ready, b_rx_v, b_yumi, b_error, b_rx_v_drive;
    logic [7:0]  b_sent, b_recv, b_errc;
    assign b_rx_v    = (b_tx_v & b_ready) | b_rx_v_drive;
    assign b_rx_data = (|b_rx_v_drive) ? 16'h0000 : b_tx_data;

    bsg_link_traffic_node #(
        .width_p(8), .channels_p(2), .cnt_width_p(4), .offset_p(32'h0000_0085), .quiet_p(8)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(b_start), .en_i(b_en),
        .burst_mode_i(b_burst), .burst_len_i(b_len),
        .tx_data_o(b_tx_data), .tx_v_o(b_tx_v), .tx_ready_i(b_ready),
        .rx_data_i(b_rx_data), .rx_v_i(b_rx_v), .rx_yumi_o(b_yumi),
        .sent_o(b_sent), .received_o(b_recv), .err_count_o(b_errc), .error_o(b_error),
        .busy_o(b_busy), .done_o(b_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pay(input longint k, input int c);
        longint v;
        v = k + longint'(c) * longint'(Off);
        return v[31:0];
    endfunction

    // Reference model of instance A: mode 0 idle, 1 run, 2 drain, 3 done.
    int          m_st = 0;
    bit          m_burst = 1'b0;
    int          m_len = 0;
    int          m_quiet = 0;
    longint      m_sent [2] = '{0, 0};
    longint      m_recv [2] = '{0, 0};
    longint      m_err  [2] = '{0, 0};
    longint      m_rxk  [2] = '{0, 0};
    bit          m_error[2] = '{0, 0};
    bit          m_hold [2] = '{0, 0};
    logic [31:0] m_hold_data[2];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_st = 0; m_quiet = 0;
            for (int c = 0; c < 2; c++) begin
                m_sent[c] = 0; m_recv[c] = 0; m_err[c] = 0; m_rxk[c] = 0;
                m_error[c] = 0; m_hold[c] = 0;
            end
        end else begin
            bit every_sent;
            every_sent = 1'b1;
            for (int c = 0; c < 2; c++) if (m_sent[c] < m_len) every_sent = 1'b0;
            for (int c = 0; c < 2; c++) begin
                bit bad;
                bad = 1'b0;
                m_hold[c] = a_tx_v[c] && !a_ready[c];
                m_hold_data[c] = a_tx_data[c*32 +: 32];
                if (a_tx_v[c] && a_ready[c]) m_sent[c]++;
                if (a_rx_v[c]) begin
                    if (m_st == 1 || m_st == 2) begin
                        m_recv[c]++;
                        bad = (a_rx_data[c*32 +: 32] != pay(m_rxk[c], c));
                        m_rxk[c]++;
                    end else bad = 1'b1;
                end
                if (bad) begin
                    m_error[c] = 1'b1;
                    if (m_err[c] < 64'hFFFF_FFFF) m_err[c]++;
                end
            end
            if (m_st == 0 || m_st == 3) begin
                if (a_start) begin
                    m_st = 1; m_burst = a_burst; m_len = int'(a_len); m_quiet = 0;
                    for (int c = 0; c < 2; c++) begin
                        m_sent[c] = 0; m_recv[c] = 0; m_err[c] = 0; m_rxk[c] = 0;
                        m_error[c] = 0; m_hold[c] = 0;
                    end
                end
            end else if (m_st == 1) begin
                if (m_burst ? every_sent : !a_en) begin m_st = 2; m_quiet = 0; end
            end else begin
                if (|a_rx_v) m_quiet = 0;
                else m_quiet++;
                if (m_quiet == Quiet) m_st = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", a_busy, (m_st == 1) || (m_st == 2));
            chk("done", a_done, m_st == 3);
            chk("rx_yumi", a_yumi, a_rx_v);
            chk("error_flags", a_error, {m_error[1], m_error[0]});
            for (int c = 0; c < 2; c++) begin
                bit allowed;
                allowed = (m_st == 1 && (!m_burst || m_sent[c] < m_len)) || m_hold[c];
                chk("sent", a_sent[c*32 +: 32], m_sent[c][31:0]);
                chk("received", a_recv[c*32 +: 32], m_recv[c][31:0]);
                chk("err_count", a_errc[c*32 +: 32], m_err[c][31:0]);
                if (a_tx_v[c]) begin
                    chk("tx_v_legal", allowed, 1'b1);
                    chk("tx_payload", a_tx_data[c*32 +: 32], pay(m_sent[c], c));
                end
                if (m_hold[c]) begin
                    chk("stall_v_held", a_tx_v[c], 1'b1);
                    chk("stall_data_held", a_tx_data[c*32 +: 32], m_hold_data[c]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int budget, input bit rnd);
        int n;
        n = 0;
        while (!a_done && n < budget) begin
            if (rnd) a_ready = 2'($urandom_range(0, 3));
            tick();
            n++;
        end
        chk("a_reached_done", a_done, 1'b1);
        a_ready = 2'b11;
    endtask

    int b_k[2] = '{0, 0};

    task automatic b_tick();
        for (int c = 0; c < 2; c++) begin
            if (b_tx_v[c]) begin
                int v;
                logic [7:0] e;
                v = b_k[c] + c * 'h85;
                e = v[7:0];
                chk("b_payload", b_tx_data[c*8 +: 8], e);
                if (b_ready[c]) b_k[c]++;
            end
        end
        tick();
    endtask

    initial begin
        int n;
        a_start = 0; a_en = 0; a_burst = 0; a_len = 0; a_ready = 0; a_loop = 1;
        a_corrupt = '0; a_rx_drive = '0; a_rx_v_drive = '0;
        b_start = 0; b_en = 0; b_burst = 0; b_len = 0; b_ready = 2'b11; b_rx_v_drive = '0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_tx_v", a_tx_v, 2'b00);
        chk("rst_tx_data", a_tx_data, 64'h0);
        chk("rst_sent", a_sent, 64'h0);
        chk("rst_error", a_error, 2'b00);
        chk("rst_b_tx_v", b_tx_v, 2'b00);
        rst_n = 1;
        chk_en = 1;
        tick();

        // Loopback burst of 100, ready held; a stray start and a len change mid-run are ignored.
        a_ready = 2'b11; a_burst = 1; a_len = 16'd100; a_start = 1;
        tick();
        a_start = 0; a_len = 16'd5;
        chk("t2_first_valid", a_tx_v, 2'b11);
        chk("t2_first_payload", a_tx_data, 64'h1000_0000_0000_0000);
        tick();
        chk("t2_second_payload", a_tx_data, 64'h1000_0001_0000_0001);
        repeat (20) tick();
        a_start = 1;
        tick();
        a_start = 0;
        wait_done_a(400, 1'b0);
        chk("t2_sent", a_sent, {32'd100, 32'd100});
        chk("t2_received", a_recv, {32'd100, 32'd100});
        chk("t2_error", a_error, 2'b00);

        // Continuous mode with random backpressure, enable dropped after 5000 cycles.
        a_burst = 0; a_en = 1; a_start = 1;
        tick();
        a_start = 0;
        for (int i = 0; i < 5000; i++) begin
            a_ready = 2'($urandom_range(0, 3));
            tick();
        end
        a_en = 0;
        wait_done_a(600, 1'b1);
        chk("t3_progress", a_sent[31:0] > 32'd1000, 1'b1);
        chk("t3_err_count", a_errc, 64'h0);
        chk("t3_error", a_error, 2'b00);

        // One corrupted payload on channel 1.
        a_burst = 1; a_len = 16'd20; a_start = 1;
        tick();
        a_start = 0;
        repeat (3) tick();
        a_corrupt = 64'h0000_0001_0000_0000;
        tick();
        a_corrupt = '0;
        wait_done_a(300, 1'b0);
        chk("t4_error", a_error, 2'b10);
        chk("t4_err_count", a_errc, {32'd1, 32'd0});
        chk("t4_sent", a_sent, {32'd20, 32'd20});

        // Zero-length burst: RUN for one cycle, then DRAIN, never a valid.
        a_len = 16'd0; a_start = 1;
        tick();
        a_start = 0;
        chk("t5_run_busy", a_busy, 1'b1);
        chk("t5_run_no_valid", a_tx_v, 2'b00);
        tick();
        chk("t5_drain_busy", a_busy, 1'b1);
        chk("t5_drain_no_valid", a_tx_v, 2'b00);
        wait_done_a(200, 1'b0);
        chk("t5_sent", a_sent, 64'h0);

        // A packet consumed in DONE is an error even with the expected data.
        a_loop = 0; a_rx_drive = '0; a_rx_v_drive = 2'b01;
        tick();
        a_rx_v_drive = '0;
        tick();
        chk("t7_err_count", a_errc, {32'd0, 32'd1});
        chk("t7_received", a_recv, 64'h0);
        chk("t7_error", a_error, 2'b01);
        a_loop = 1;

        // Reset pulse mid-run, then restart from k = 0.
        a_burst = 0; a_en = 1; a_start = 1;
        tick();
        a_start = 0;
        repeat (10) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t6_busy", a_busy, 1'b0);
        chk("t6_done", a_done, 1'b0);
        chk("t6_tx_v", a_tx_v, 2'b00);
        chk("t6_tx_data", a_tx_data, 64'h0);
        chk("t6_sent", a_sent, 64'h0);
        chk("t6_err", a_errc, 64'h0);
        a_burst = 1; a_len = 16'd5; a_start = 1;
        tick();
        a_start = 0;
        chk("t6_restart_payload", a_tx_data, 64'h1000_0000_0000_0000);
        wait_done_a(200, 1'b0);
        chk("t6_sent_after", a_sent, {32'd5, 32'd5});

        // Narrow instance: payload and counter wrap over 300+ packets.
        b_en = 1; b_start = 1;
        b_tick();
        b_start = 0;
        for (int i = 0; i < 310; i++) b_tick();
        b_en = 0;
        n = 0;
        while (!b_done && n < 200) begin
            b_tick();
            n++;
        end
        chk("b_reached_done", b_done, 1'b1);
        chk("b_wrapped", b_k[0] >= 300, 1'b1);
        chk("b_sent0", b_sent[3:0], 4'(b_k[0]));
        chk("b_sent1", b_sent[7:4], 4'(b_k[1]));
        chk("b_recv0", b_recv[3:0], 4'(b_k[0]));
        chk("b_err_none", b_errc, 8'h00);
        chk("b_error_none", b_error, 2'b00);

        // Saturation: 20 packets on channel 1 while DONE, counter is 4 bits wide.
        b_rx_v_drive = 2'b10;
        repeat (20) tick();
        b_rx_v_drive = '0;
        tick();
        chk("b_err_saturated", b_errc[7:4], 4'hF);
        chk("b_err_ch0", b_errc[3:0], 4'h0);
        chk("b_error_flags", b_error, 2'b10);
        chk("b_recv1_unchanged", b_recv[7:4], 4'(b_k[1]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
